// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for the 5-stage core: load-use and branch-operand
// hazards, multi-cycle multiply occupancy of EX, global freeze and a stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Valid_i,
  input  logic [4:0]       ID_RegSrc1_i,
  input  logic [4:0]       ID_RegSrc2_i,
  input  logic             ID_UseSrc1_i,
  input  logic             ID_UseSrc2_i,
  input  logic             ID_Branch_i,
  input  logic             ID_RegWrite_i,
  input  logic [4:0]       ID_RegDest_i,
  input  logic             ID_MemRead_i,
  input  logic             ID_Mul_i,
  input  logic             Branch_Taken_i,
  input  logic             Mem_Stall_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_Hold_o,
  output logic             EX_MEM_Bubble_o,
  output logic             Freeze_All_o,
  output logic             Mul_Busy_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned MCNT_W = 4;
  localparam bit          MUL_MULTI = (MUL_LAT > 32'd1);

  typedef enum logic {ST_RUN, ST_MUL_WAIT} state_t;

  state_t             r_state;
  logic [MCNT_W-1:0]  r_mul_cnt;
  logic               r_ex_wr, r_ex_load, r_mem_wr, r_mem_load;
  logic [REG_W-1:0]   r_ex_dest, r_mem_dest;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_run, w_ex_match, w_mem_match, w_load_use, w_br_hazard, w_hz, w_bubble, w_mul_start;

  // Does the valid ID instruction read a nonzero register held by EX / MEM?
  assign w_ex_match  = ID_Valid_i & (r_ex_dest != '0) &
                       ((ID_UseSrc1_i & (r_ex_dest == ID_RegSrc1_i)) |
                        (ID_UseSrc2_i & (r_ex_dest == ID_RegSrc2_i)));
  assign w_mem_match = ID_Valid_i & (r_mem_dest != '0) &
                       ((ID_UseSrc1_i & (r_mem_dest == ID_RegSrc1_i)) |
                        (ID_UseSrc2_i & (r_mem_dest == ID_RegSrc2_i)));

  assign w_run       = (r_state == ST_RUN);
  assign w_load_use  = r_ex_wr & r_ex_load & w_ex_match;
  assign w_br_hazard = ID_Branch_i & r_mem_wr & r_mem_load & w_mem_match;
  assign w_hz        = w_run & (w_load_use | w_br_hazard);
  assign w_bubble    = w_hz | ~ID_Valid_i;
  assign w_mul_start = w_run & ID_Valid_i & ID_Mul_i & ~w_hz & MUL_MULTI;

  // Pipeline controls; freeze overrides everything
  always_comb begin
    PC_Write_o      = 1'b0;
    IF_ID_Write_o   = 1'b0;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Bubble_o  = 1'b0;
    EX_Hold_o       = 1'b0;
    EX_MEM_Bubble_o = 1'b0;
    Freeze_All_o    = Mem_Stall_i;
    if (!Mem_Stall_i) begin
      if (!w_run) begin
        EX_Hold_o       = 1'b1;
        EX_MEM_Bubble_o = 1'b1;
      end else if (w_hz) begin
        ID_EX_Bubble_o  = 1'b1;
      end else begin
        PC_Write_o      = 1'b1;
        IF_ID_Write_o   = 1'b1;
        ID_EX_Bubble_o  = ~ID_Valid_i;
        IF_ID_Flush_o   = Branch_Taken_i;
      end
    end
  end

  assign Mul_Busy_o  = ~w_run;
  assign Stall_Cnt_o = r_stall_cnt;

  // Shadow EX/MEM destination info, multiply FSM and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_mul_cnt   <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_dest   <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_dest  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (!PC_Write_o && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!Mem_Stall_i) begin
        if (w_run) begin
          r_mem_wr   <= r_ex_wr;
          r_mem_load <= r_ex_load;
          r_mem_dest <= r_ex_dest;
          r_ex_wr    <= ~w_bubble & ID_RegWrite_i;
          r_ex_load  <= ~w_bubble & ID_MemRead_i;
          r_ex_dest  <= w_bubble ? '0 : ID_RegDest_i;
          if (w_mul_start) begin
            r_state   <= ST_MUL_WAIT;
            r_mul_cnt <= MCNT_W'(MUL_LAT - 1);
          end
        end else begin
          r_mem_wr   <= 1'b0;
          r_mem_load <= 1'b0;
          r_mem_dest <= '0;
          r_mul_cnt  <= r_mul_cnt - MCNT_W'(1);
          if (r_mul_cnt == MCNT_W'(1))
            r_state <= ST_RUN;
        end
      end
    end
  end

endmodule
